cp0_regs: RTL and testbench



---
 rtl/cp0_regs_pkg.sv | 64 ++++++
 rtl/cp0_timer.sv | 74 +++++++
 rtl/cp0_regs.sv | 214 +++++++++++++++++++++
 tb/tb_cp0_regs.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_regs_pkg.sv
//==============================================================================
// Module      : cp0_regs_pkg
// Description : Shared constants for the CP0 register block: bus widths,
//               CP0 register numbers, Status/Cause field positions, reset
//               values and the exception codes CP0 reacts to.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cp0_regs_pkg;

    // Bus widths
    localparam int W_DATA = 32;
    localparam int W_ADDR = 32;
    localparam int W_EXCC = 5;
    localparam int W_INTV = 8;
    localparam int W_REGN = 5;

    // CP0 register numbers
    localparam logic [W_REGN-1:0] C_REG_BADVADDR = 5'd8;
    localparam logic [W_REGN-1:0] C_REG_COUNT    = 5'd9;
    localparam logic [W_REGN-1:0] C_REG_COMPARE  = 5'd11;
    localparam logic [W_REGN-1:0] C_REG_STATUS   = 5'd12;
    localparam logic [W_REGN-1:0] C_REG_CAUSE    = 5'd13;
    localparam logic [W_REGN-1:0] C_REG_EPC      = 5'd14;

    // Status field positions
    localparam int C_STATUS_IE     = 0;
    localparam int C_STATUS_EXL    = 1;
    localparam int C_STATUS_IM_LO  = 8;
    localparam int C_STATUS_IM_HI  = 15;
    localparam int C_STATUS_BEV    = 22;

    // Cause field positions
    localparam int C_CAUSE_EXC_LO  = 2;
    localparam int C_CAUSE_EXC_HI  = 6;
    localparam int C_CAUSE_IPSW_LO = 8;
    localparam int C_CAUSE_IPSW_HI = 9;
    localparam int C_CAUSE_IPHW_LO = 10;
    localparam int C_CAUSE_IPHW_HI = 15;
    localparam int C_CAUSE_TI      = 30;
    localparam int C_CAUSE_BD      = 31;

    // Reset values
    localparam logic [W_DATA-1:0] C_STATUS_RST = 32'h0040_0000;
    localparam logic [W_DATA-1:0] C_ZERO_RST   = 32'h0000_0000;

    // Exception codes
    localparam logic [W_EXCC-1:0] C_EXCC_INT  = 5'd0;
    localparam logic [W_EXCC-1:0] C_EXCC_ADEL = 5'd4;
    localparam logic [W_EXCC-1:0] C_EXCC_ADES = 5'd5;
    localparam logic [W_EXCC-1:0] C_EXCC_SY   = 5'd8;
    localparam logic [W_EXCC-1:0] C_EXCC_BP   = 5'd9;
    localparam logic [W_EXCC-1:0] C_EXCC_RI   = 5'd10;
    localparam logic [W_EXCC-1:0] C_EXCC_OV   = 5'd12;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [W_EXCC-1:0] code);
        return (code == C_EXCC_ADEL) || (code == C_EXCC_ADES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
//==============================================================================
// Module      : cp0_timer
// Description : Count/Compare timer with the TI (timer interrupt) flag.
//               Count advances once every two clocks, paced by an internal
//               tick flop. TI sets when an increment lands on Compare and
//               clears on any write to Compare.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               count_we           - load Count from wdata (beats increment)
//               compare_we         - load Compare from wdata, clear TI
//               wdata              - write data
//               count, compare, ti - registered state
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cp0_timer
    import cp0_regs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              count_we,
    input  logic              compare_we,
    input  logic [W_DATA-1:0] wdata,
    output logic [W_DATA-1:0] count,
    output logic [W_DATA-1:0] compare,
    output logic              ti
);

    logic              r_tick;
    logic [W_DATA-1:0] r_count;
    logic [W_DATA-1:0] r_compare;
    logic              r_ti;
    logic [W_DATA-1:0] w_count_inc;

    // Natural 32-bit wrap from 0xFFFFFFFF to 0.
    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= 1'b0;
            r_count   <= C_ZERO_RST;
            r_compare <= C_ZERO_RST;
            r_ti      <= 1'b0;
        end else begin
            // The tick free-runs; a Count write does not re-phase it.
            r_tick <= ~r_tick;

            if (count_we) begin
                r_count <= wdata;
            end else if (r_tick) begin
                r_count <= w_count_inc;
            end

            if (compare_we) begin
                r_compare <= wdata;
            end

            // Compare write acknowledges the interrupt and wins over a
            // same-cycle match. A match is only judged on a real increment.
            if (compare_we) begin
                r_ti <= 1'b0;
            end else if (!count_we && r_tick && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign count   = r_count;
    assign compare = r_compare;
    assign ti      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_regs.sv
//==============================================================================
// Module      : cp0_regs
// Description : MIPS CP0 register file subset: BadVAddr(8), Count(9),
//               Compare(11), Status(12), Cause(13), EPC(14). Handles mtc0
//               writes, mfc0 reads, exception commit, eret and interrupt
//               masking.
// Config      : CP0_TIMER_INT_EN - when defined, the cp0_timer sub-module
//               provides Count/Compare/TI. When undefined, Compare reads 0,
//               TI is 0 and a local Count still runs.
// Ports       : clk, rst                 - clock, sync active-high reset
//               hw_int[5:0]              - external interrupt lines
//               we, waddr, wdata         - mtc0 write port
//               raddr, rdata             - mfc0 read port (combinational)
//               eret                     - eret commit
//               cp0_en, cp0_bd, cp0_exl  - exception commit controls
//               cp0_exc, cp0_epc, cp0_bva- exception code, victim PC, bad VA
//               intr_vect[7:0]           - pending enabled interrupts
//               epc                      - current EPC (eret target)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cp0_regs
    import cp0_regs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        hw_int,
    input  logic              we,
    input  logic [W_REGN-1:0] waddr,
    input  logic [W_DATA-1:0] wdata,
    input  logic [W_REGN-1:0] raddr,
    output logic [W_DATA-1:0] rdata,
    input  logic              eret,
    input  logic              cp0_en,
    input  logic              cp0_bd,
    input  logic              cp0_exl,
    input  logic [W_EXCC-1:0] cp0_exc,
    input  logic [W_ADDR-1:0] cp0_epc,
    input  logic [W_ADDR-1:0] cp0_bva,
    output logic [W_INTV-1:0] intr_vect,
    output logic [W_ADDR-1:0] epc
);

    // Status state
    logic [7:0]        r_status_im;
    logic              r_status_exl;
    logic              r_status_ie;

    // Cause state
    logic              r_cause_bd;
    logic [1:0]        r_cause_ip_sw;
    logic [5:0]        r_cause_ip_hw;
    logic [W_EXCC-1:0] r_cause_exc;

    logic [W_ADDR-1:0] r_epc;
    logic [W_ADDR-1:0] r_badvaddr;

    // Timer view
    logic [W_DATA-1:0] w_count;
    logic [W_DATA-1:0] w_compare;
    logic              w_ti;

    // Decoded mtc0 strobes
    logic              w_wr_count;
    logic              w_wr_compare;
    logic              w_wr_status;
    logic              w_wr_cause;
    logic              w_wr_epc;

    // Read views
    logic [7:0]        w_ip;
    logic [W_DATA-1:0] w_status_rd;
    logic [W_DATA-1:0] w_cause_rd;

    // An exception commit only captures EPC/BD for the first-level fault.
    logic              w_exc_capture;

    assign w_wr_count   = we && (waddr == C_REG_COUNT);
    assign w_wr_compare = we && (waddr == C_REG_COMPARE);
    assign w_wr_status  = we && (waddr == C_REG_STATUS);
    assign w_wr_cause   = we && (waddr == C_REG_CAUSE);
    assign w_wr_epc     = we && (waddr == C_REG_EPC);

    assign w_exc_capture = cp0_en && !r_status_exl;

`ifdef CP0_TIMER_INT_EN
    cp0_timer u_cp0_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (w_wr_count),
        .compare_we (w_wr_compare),
        .wdata      (wdata),
        .count      (w_count),
        .compare    (w_compare),
        .ti         (w_ti)
    );
`else
    logic              r_tick;
    logic [W_DATA-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick  <= 1'b0;
            r_count <= C_ZERO_RST;
        end else begin
            r_tick <= ~r_tick;
            if (w_wr_count) begin
                r_count <= wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign w_count   = r_count;
    assign w_compare = C_ZERO_RST;
    assign w_ti      = 1'b0;
`endif

    // Status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status_im  <= C_STATUS_RST[C_STATUS_IM_HI:C_STATUS_IM_LO];
            r_status_exl <= C_STATUS_RST[C_STATUS_EXL];
            r_status_ie  <= C_STATUS_RST[C_STATUS_IE];
        end else begin
            if (w_wr_status) begin
                r_status_im <= wdata[C_STATUS_IM_HI:C_STATUS_IM_LO];
                r_status_ie <= wdata[C_STATUS_IE];
            end

            // EXL has three writers; an exception commit owns the field
            // for its cycle even when it does not request EXL.
            if (cp0_en) begin
                if (cp0_exl) begin
                    r_status_exl <= 1'b1;
                end
            end else if (eret) begin
                r_status_exl <= 1'b0;
            end else if (w_wr_status) begin
                r_status_exl <= wdata[C_STATUS_EXL];
            end
        end
    end

    // Cause, EPC, BadVAddr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause_bd    <= 1'b0;
            r_cause_ip_sw <= 2'b00;
            r_cause_ip_hw <= 6'b000000;
            r_cause_exc   <= C_EXCC_INT;
            r_epc         <= C_ZERO_RST;
            r_badvaddr    <= C_ZERO_RST;
        end else begin
            r_cause_ip_hw <= hw_int;

            if (w_wr_cause) begin
                r_cause_ip_sw <= wdata[C_CAUSE_IPSW_HI:C_CAUSE_IPSW_LO];
            end

            if (cp0_en) begin
                r_cause_exc <= cp0_exc;
            end

            if (w_exc_capture) begin
                r_cause_bd <= cp0_bd;
            end

            if (w_exc_capture) begin
                r_epc <= cp0_epc;
            end else if (w_wr_epc) begin
                r_epc <= wdata;
            end

            if (cp0_en && is_addr_exc(cp0_exc)) begin
                r_badvaddr <= cp0_bva;
            end
        end
    end

    // Timer interrupt shares the IP7 line with hw_int[5].
    assign w_ip = {r_cause_ip_hw[5] | w_ti, r_cause_ip_hw[4:0], r_cause_ip_sw};

    assign w_status_rd = {9'b0, 1'b1, 6'b0, r_status_im, 6'b0,
                          r_status_exl, r_status_ie};

    assign w_cause_rd  = {r_cause_bd, w_ti, 14'b0, w_ip, 1'b0,
                          r_cause_exc, 2'b00};

    // Read mux reflects state before the edge; no write forwarding.
    always_comb begin
        rdata = C_ZERO_RST;
        case (raddr)
            C_REG_BADVADDR: rdata = r_badvaddr;
            C_REG_COUNT:    rdata = w_count;
            C_REG_COMPARE:  rdata = w_compare;
            C_REG_STATUS:   rdata = w_status_rd;
            C_REG_CAUSE:    rdata = w_cause_rd;
            C_REG_EPC:      rdata = r_epc;
            default:        rdata = C_ZERO_RST;
        endcase
    end

    // Held at zero while reset is asserted, independent of stored state.
    assign intr_vect = (r_status_ie && !r_status_exl && !rst)
                       ? (w_ip & r_status_im) : {W_INTV{1'b0}};

    assign epc = r_epc;

endmodule

`default_nettype wire

// File: tb/tb_cp0_regs.sv
//==============================================================================
// Module      : tb_cp0_regs
// Description : Self-checking bench for cp0_regs: directed scenarios then
//               randomized traffic checked against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cp0_regs;

`ifdef CP0_TIMER_INT_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        eret;
    logic        cp0_en;
    logic        cp0_bd;
    logic        cp0_exl;
    logic [4:0]  cp0_exc;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_bva;
    logic [7:0]  intr_vect;
    logic [31:0] epc;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_regs dut (
        .clk       (clk),
        .rst       (rst),
        .hw_int    (hw_int),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .eret      (eret),
        .cp0_en    (cp0_en),
        .cp0_bd    (cp0_bd),
        .cp0_exl   (cp0_exl),
        .cp0_exc   (cp0_exc),
        .cp0_epc   (cp0_epc),
        .cp0_bva   (cp0_bva),
        .intr_vect (intr_vect),
        .epc       (epc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: architectural fields
    bit          m_valid = 1'b0;
    logic [31:0] m_count, m_compare, m_epc, m_bva;
    logic        m_ti, m_tick, m_exl, m_ie, m_bd;
    logic [7:0]  m_im;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [7:0] model_intr();
        return (m_ie && !m_exl) ? (model_ip() & m_im) : 8'h00;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            5'd8:  v = m_bva;
            5'd9:  v = m_count;
            5'd11: v = TIMER_ON ? m_compare : 32'h0;
            5'd12: v = 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
            5'd13: v = (32'(m_bd) << 31) + (32'(m_ti) << 30) + (32'(model_ip()) << 8)
                       + (32'(m_exc) << 2);
            5'd14: v = m_epc;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Applies one clock edge of the architectural rules to the model.
    task automatic model_update();
        logic        old_exl;
        logic [31:0] next_count;
        if (rst) begin
            m_valid = 1'b1;
            m_count = 0; m_compare = 0; m_epc = 0; m_bva = 0;
            m_ti = 0; m_tick = 0; m_exl = 0; m_ie = 0; m_bd = 0;
            m_im = 0; m_exc = 0; m_ipsw = 0; m_hw = 0;
            return;
        end
        old_exl = m_exl;
        m_hw = hw_int;

        // Status
        if (we && waddr == 5'd12) begin
            m_im = wdata[15:8];
            m_ie = wdata[0];
        end
        if (cp0_en) begin
            if (cp0_exl) m_exl = 1'b1;
        end else if (eret) begin
            m_exl = 1'b0;
        end else if (we && waddr == 5'd12) begin
            m_exl = wdata[1];
        end

        // Exception commit
        if (cp0_en) begin
            m_exc = cp0_exc;
            if (cp0_exc == 5'd4 || cp0_exc == 5'd5) m_bva = cp0_bva;
        end
        if (cp0_en && !old_exl) begin
            m_bd  = cp0_bd;
            m_epc = cp0_epc;
        end else if (we && waddr == 5'd14) begin
            m_epc = wdata;
        end
        if (we && waddr == 5'd13) m_ipsw = wdata[9:8];

        // Timer: one increment per two clocks
        next_count = m_count;
        if (we && waddr == 5'd9) begin
            next_count = wdata;
        end else if (m_tick) begin
            next_count = m_count + 1;
            if (TIMER_ON && next_count == m_compare && !(we && waddr == 5'd11))
                m_ti = 1'b1;
        end
        if (TIMER_ON && we && waddr == 5'd11) begin
            m_compare = wdata;
            m_ti      = 1'b0;
        end
        m_count = next_count;
        m_tick  = !m_tick;
    endtask

    // Called at a negedge with inputs already driven; returns at next negedge.
    task automatic step();
        #1;
        if (m_valid) begin
            check("rdata", rdata, model_read(raddr));
            check("intr_vect", {24'h0, intr_vect}, rst ? 32'h0 : {24'h0, model_intr()});
            check("epc", epc, m_epc);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        raddr = a;
        #1;
        d = rdata;
    endtask

    task automatic idle_inputs();
        we = 0; waddr = 0; wdata = 0; eret = 0;
        cp0_en = 0; cp0_bd = 0; cp0_exl = 0; cp0_exc = 0; cp0_epc = 0; cp0_bva = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1; waddr = a; wdata = d;
        step();
        we = 0;
    endtask

    logic [31:0] d;
    bit          done;

    initial begin
        rst = 1; hw_int = 0; raddr = 0;
        idle_inputs();
        @(negedge clk);
        step();
        step();
        rst = 0;

        // Reset release
        rd(5'd12, d); check("rst_status", d, 32'h0040_0000);
        rd(5'd13, d); check("rst_cause", d, 32'h0);
        rd(5'd14, d); check("rst_epc", d, 32'h0);
        check("rst_intr", {24'h0, intr_vect}, 32'h0);

        // Interrupt masking
        mtc0(5'd12, 32'h0000_FF01);
        hw_int = 6'b000001;
        step();
        check("intr_hw0", {24'h0, intr_vect}, 32'h04);
        step();
        check("intr_hw0_hold", {24'h0, intr_vect}, 32'h04);
        hw_int = 0;
        step();

        // First-level exception: address error on load, in delay slot
        cp0_en = 1; cp0_exc = 5'd4; cp0_epc = 32'hBFC0_0010; cp0_bva = 32'h3;
        cp0_bd = 1; cp0_exl = 1;
        step();
        idle_inputs();
        rd(5'd14, d); check("exc1_epc", d, 32'hBFC0_0010);
        rd(5'd8,  d); check("exc1_bva", d, 32'h3);
        rd(5'd13, d); check("exc1_cause", d, 32'h8000_0010);
        rd(5'd12, d); check("exc1_status", d, 32'h0040_FF03);
        check("exc1_intr_masked", {24'h0, intr_vect}, 32'h0);

        // Nested exception: EPC/BD/BadVAddr keep first values
        cp0_en = 1; cp0_exc = 5'd8; cp0_epc = 32'h1234; cp0_bva = 32'hDEAD; cp0_exl = 1;
        step();
        idle_inputs();
        rd(5'd14, d); check("exc2_epc", d, 32'hBFC0_0010);
        rd(5'd8,  d); check("exc2_bva", d, 32'h3);
        rd(5'd13, d); check("exc2_cause", d, 32'h8000_0020);

        // eret, then cp0_en+eret together, then eret alone
        eret = 1; step(); eret = 0;
        rd(5'd12, d); check("eret_exl0", {31'h0, d[1]}, 32'h0);
        cp0_en = 1; cp0_exl = 1; cp0_exc = 5'd10; cp0_epc = 32'h400; eret = 1;
        step();
        idle_inputs();
        rd(5'd12, d); check("en_eret_exl1", {31'h0, d[1]}, 32'h1);
        eret = 1; step(); eret = 0;
        rd(5'd12, d); check("eret2_exl0", {31'h0, d[1]}, 32'h0);

`ifdef CP0_TIMER_INT_EN
        // Timer interrupt
        mtc0(5'd11, 32'd4);
        mtc0(5'd9, 32'd0);
        done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            rd(5'd13, d);
            if (d[30]) done = 1;
            else step();
        end
        check("ti_set", {31'h0, done}, 32'h1);
        rd(5'd9, d); check("ti_count", d, 32'd4);
        check("ti_intr7", {31'h0, intr_vect[7]}, 32'h1);
        mtc0(5'd11, 32'd100);
        rd(5'd13, d); check("ti_clear", {31'h0, d[30]}, 32'h0);
`endif

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        done = 0;
        for (int i = 0; i < 4 && !done; i++) begin
            rd(5'd9, d);
            if (d != 32'hFFFF_FFFF) done = 1;
            else step();
        end
        check("wrap_seen", {31'h0, done}, 32'h1);
        check("wrap_zero", d, 32'h0);

        // Reset during an exception commit discards it
        rst = 1; cp0_en = 1; cp0_exc = 5'd4; cp0_epc = 32'h55; cp0_bva = 32'h66; cp0_exl = 1;
        step();
        rst = 0; idle_inputs();
        rd(5'd14, d); check("rstexc_epc", d, 32'h0);
        rd(5'd8,  d); check("rstexc_bva", d, 32'h0);
        rd(5'd12, d); check("rstexc_status", d, 32'h0040_0000);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [4:0] pick [7];
            pick[0] = 5'd8;  pick[1] = 5'd9;  pick[2] = 5'd11; pick[3] = 5'd12;
            pick[4] = 5'd13; pick[5] = 5'd14; pick[6] = 5'($urandom_range(0, 31));
            rst     = ($urandom_range(0, 149) == 0);
            hw_int  = 6'($urandom);
            we      = ($urandom_range(0, 2) == 0);
            waddr   = pick[$urandom_range(0, 6)];
            wdata   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 9));
            if (waddr == 5'd12 && $urandom_range(0, 1) == 1) wdata[1] = 1'b0;
            raddr   = pick[$urandom_range(0, 6)];
            eret    = ($urandom_range(0, 7) == 0);
            cp0_en  = ($urandom_range(0, 9) == 0);
            cp0_bd  = 1'($urandom);
            cp0_exl = 1'($urandom);
            case ($urandom_range(0, 3))
                0: cp0_exc = 5'd4;
                1: cp0_exc = 5'd5;
                2: cp0_exc = 5'd8;
                default: cp0_exc = 5'($urandom);
            endcase
            cp0_epc = $urandom;
            cp0_bva = $urandom;
            step();
        end
        rst = 0; idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
